// File: rtl/mac_seq_pkg.sv
// Shared types and helpers for the MAC lane sequencer.
// Optional systolic skew of lane issue is enabled with MAC_SEQ_SKEW_EN.
package mac_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Width of a counter that must hold 0 .. n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mac_seq_if.sv
// Command, FIFO and MAC-array signals of the sequencer, grouped as one bundle.
// The master side issues jobs and reports FIFO state; the slave side is the sequencer.
interface mac_seq_if #(
    parameter int LANES = 8,
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic [LANES-1:0] fifo_empty;
    logic [LANES-1:0] fifo_rd;
    logic [LANES-1:0] mac_en;
    logic             mac_clr;
    logic             busy;
    logic             done;

    modport master (
        output start, len, abort, fifo_empty,
        input  fifo_rd, mac_en, mac_clr, busy, done
    );

    modport slave (
        input  start, len, abort, fifo_empty,
        output fifo_rd, mac_en, mac_clr, busy, done
    );
endinterface

// File: rtl/mac_seq_skew.sv
// Issue delay line for the systolic (MAC_SEQ_SKEW_EN) build: lane i fires i cycles after lane 0,
// and a pending pulse for an empty lane freezes the whole line so no empty FIFO is ever popped.
module mac_seq_skew #(
    parameter int LANES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             want,
    input  logic [LANES-1:0] fifo_empty,
    output logic [LANES-1:0] fire,
    output logic             stall
);
    logic [LANES-1:0] pend;

    generate
        if (LANES == 1) begin : g_single
            assign pend = want;
        end else begin : g_line
            logic [LANES-2:0] dly;

            assign pend = {dly, want};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dly <= '0;
                end else if (flush) begin
                    dly <= '0;
                end else if (!stall) begin
                    dly <= pend[LANES-2:0];
                end
            end
        end
    endgenerate

    assign stall = |(pend & fifo_empty);
    assign fire  = stall ? '0 : pend;

endmodule

// File: rtl/mac_seq_ctrl.sv
// MAC lane sequencer: clear accumulators, stream len beats in lockstep, drain, pulse done.
// Define MAC_SEQ_SKEW_EN for staggered (systolic) lane issue with a longer drain.
module mac_seq_ctrl
    import mac_seq_pkg::*;
#(
    parameter int LANES     = 8,
    parameter int LEN_W     = 8,
    parameter int DRAIN_CYC = 2
) (
    input logic   clk,
    input logic   rst_n,
    mac_seq_if.slave bus
);
`ifdef MAC_SEQ_SKEW_EN
    localparam int DRAIN_TOT = DRAIN_CYC + LANES - 1;
`else
    localparam int DRAIN_TOT = DRAIN_CYC;
`endif
    localparam int DW         = cnt_width(DRAIN_TOT);
    localparam int DRAIN_LAST = (DRAIN_TOT > 0) ? DRAIN_TOT - 1 : 0;

    state_t           state, state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] beat_cnt;
    logic [DW-1:0]    drain_cnt;
    logic [LANES-1:0] fire;
    logic             stall;
    logic             issue;
    logic             last_beat;
    logic             drain_end;
    logic             mac_clr_q, busy_q, done_q;

`ifdef MAC_SEQ_SKEW_EN
    mac_seq_skew #(.LANES(LANES)) u_skew (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (bus.abort),
        .want       (state == RUN),
        .fifo_empty (bus.fifo_empty),
        .fire       (fire),
        .stall      (stall)
    );
`else
    // Lockstep issue: every lane pops together, and only when no lane is empty.
    always_comb begin
        stall = (state == RUN) && (|bus.fifo_empty);
        fire  = '0;
        if (state == RUN && !stall) fire = '1;
    end
`endif

    assign issue     = fire[0];
    assign last_beat = issue && (beat_cnt == len_q - LEN_W'(1));
    assign drain_end = !stall && (drain_cnt == DW'(DRAIN_LAST));

    always_comb begin
        state_d = state;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.start) state_d = CLEAR;
                CLEAR:   state_d = (len_q != '0) ? RUN : DONE;
                RUN:     if (last_beat) state_d = (DRAIN_TOT == 0) ? DONE : DRAIN;
                DRAIN:   if (drain_end) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with the registered state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            len_q     <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            mac_clr_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_d;
            mac_clr_q <= (state_d == CLEAR);
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_d == DONE);
            if (bus.abort) begin
                beat_cnt  <= '0;
                drain_cnt <= '0;
            end else begin
                if (state == IDLE && bus.start) len_q <= bus.len;
                if (state == CLEAR)  beat_cnt <= '0;
                else if (issue)      beat_cnt <= beat_cnt + LEN_W'(1);
                if (state != DRAIN)  drain_cnt <= '0;
                else if (!stall)     drain_cnt <= drain_cnt + DW'(1);
            end
        end
    end

    assign bus.fifo_rd = fire;
    assign bus.mac_en  = fire;
    assign bus.mac_clr = mac_clr_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule
